rom_download_packer: RTL and testbench

ROM_DOWNLOAD_PACKER -- requirements
Module: rom_download_packer

---
 rtl/rom_download_packer.sv | 197 +++++++++++++++++++
 tb/tb_rom_download_packer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_packer.sv
// Packs ioctl download bytes into 32-bit little-endian words and writes them to SDRAM through a word FIFO.
// Latency: lane-3 byte sampled at cycle N -> FIFO entry at N+1 -> sdram_req at N+2 (FSM idle, FIFO empty).
// Backpressure: none toward ioctl; a push into a full FIFO with no pop that cycle is dropped and sets overflow.
module rom_download_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_data,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [31:0]           sdram_data,
    output logic                  sdram_we,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } entry_t;

    // assembly path
    logic                  dl_q;
    logic [31:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] asm_addr_q, asm_addr_d;
    logic                  pending_q, pending_d;
    logic                  flush_q, flush_d;
    logic                  overflow_q, overflow_d;

    // fifo
    entry_t                mem_q [FIFO_DEPTH];
    logic [PW:0]           wptr_q, rptr_q;
    entry_t                push_ent, head;
    logic                  push, push_ok, pop, drop, empty, full;

    // write fsm
    state_t                state_q;
    logic                  req_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic                  busy_q, done_q;

    logic                  accept, dl_rise, dl_fall, pend_live, old_out, lane3;
    logic [ADDR_WIDTH-1:0] byte_waddr;
    logic [4:0]            sh;
    logic [31:0]           byte_word, lane_mask, merge_base, merged;

    assign accept     = ioctl_wr && ioctl_download;
    assign dl_rise    = ioctl_download && !dl_q;
    assign dl_fall    = !ioctl_download && dl_q;
    assign byte_waddr = ADDR_WIDTH'(ioctl_addr[24:2]);
    assign lane3      = (ioctl_addr[1:0] == 2'd3);
    assign sh         = {ioctl_addr[1:0], 3'b000};
    assign byte_word  = 32'(ioctl_data) << sh;
    assign lane_mask  = 32'hFF << sh;

    // A rising download edge discards whatever partial word is left over.
    assign pend_live  = pending_q && !dl_rise;
    assign old_out    = pend_live && (flush_q || dl_fall || (accept && (byte_waddr != asm_addr_q)));
    assign merge_base = (pend_live && !old_out) ? asm_q : 32'h0;
    assign merged     = (merge_base & ~lane_mask) | byte_word;

    always_comb begin
        push       = 1'b0;
        push_ent   = '0;
        asm_d      = asm_q;
        asm_addr_d = asm_addr_q;
        pending_d  = pending_q;
        flush_d    = 1'b0;
        if (dl_rise) begin
            asm_d     = 32'h0;
            pending_d = 1'b0;
        end
        if (old_out) begin
            push          = 1'b1;
            push_ent.addr = asm_addr_q;
            push_ent.data = asm_q;
            asm_d         = 32'h0;
            pending_d     = 1'b0;
        end
        if (accept) begin
            if (lane3 && !old_out) begin
                push          = 1'b1;
                push_ent.addr = byte_waddr;
                push_ent.data = merged;
                asm_d         = 32'h0;
                pending_d     = 1'b0;
            end else begin
                // A completed word that collides with an eviction is pushed next cycle via flush.
                asm_d      = merged;
                asm_addr_d = byte_waddr;
                pending_d  = 1'b1;
                flush_d    = lane3;
            end
        end
    end

    assign pop     = (state_q == REQ) && sdram_ack;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign head    = mem_q[rptr_q[PW-1:0]];

    always_comb begin
        overflow_d = overflow_q;
        if (dl_rise) overflow_d = 1'b0;
        if (drop)    overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            asm_q      <= 32'h0;
            asm_addr_q <= '0;
            pending_q  <= 1'b0;
            flush_q    <= 1'b0;
            overflow_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            dl_q       <= ioctl_download;
            asm_q      <= asm_d;
            asm_addr_q <= asm_addr_d;
            pending_q  <= pending_d;
            flush_q    <= flush_d;
            overflow_q <= overflow_d;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
        end
    end

    // The popped head already sits in addr_q/data_q, so overwriting its slot on a full push is safe.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[PW-1:0]] <= push_ent;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        addr_q  <= head.addr;
                        data_q  <= head.data;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = reset_n && (ioctl_download || pending_q || !empty || (state_q == REQ));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy;
            done_q <= busy_q && !busy;
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_req  = req_q;
    assign sdram_we   = req_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_download_packer.sv
// Directed bench for rom_download_packer: a word-level model predicts the SDRAM write stream,
// a negedge monitor checks every request against it, and literal expectations pin the model.
module tb_rom_download_packer;
    localparam int DEPTH = 4;
    localparam int AW    = 23;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_data = '0;
    logic [AW-1:0] sdram_addr;
    logic [31:0]   sdram_data;
    logic          sdram_we, sdram_req, busy, done, overflow;
    logic          ack_auto = 1'b0, ack_stray = 1'b0;
    logic          sdram_ack;

    assign sdram_ack = ack_auto | ack_stray;

    rom_download_packer #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data),
        .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // word-level model state
    logic [AW-1:0] exp_a[$];
    logic [31:0]   exp_d[$];
    logic [AW-1:0] obs_a[$];
    logic [31:0]   obs_d[$];
    int            outstanding = 0;
    bit            exp_ovf = 1'b0;
    bit            cur_v = 1'b0;
    logic [AW-1:0] cur_a = '0;
    logic [7:0]    cur_b[4];
    int            done_cnt = 0;
    bit            ack_en = 1'b0;
    int            ack_dly = 2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_clear_word();
        cur_v = 1'b0;
        for (int i = 0; i < 4; i++) cur_b[i] = 8'h00;
    endtask

    task automatic model_emit();
        if (outstanding < DEPTH) begin
            exp_a.push_back(cur_a);
            exp_d.push_back({cur_b[3], cur_b[2], cur_b[1], cur_b[0]});
            outstanding++;
        end else begin
            exp_ovf = 1'b1;
        end
        model_clear_word();
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was sampled.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
        if (ioctl_download) begin
            if (cur_v && (a[24:2] != cur_a)) model_emit();
            cur_v = 1'b1;
            cur_a = a[24:2];
            cur_b[a[1:0]] = d;
            if (a[1:0] == 2'd3) model_emit();
        end
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic dl_up();
        ioctl_download = 1'b1;
        model_clear_word();
        exp_ovf = 1'b0;
    endtask

    task automatic dl_down();
        ioctl_download = 1'b0;
        if (cur_v) model_emit();
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((busy || exp_a.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s_drain timeout busy=%0b queued=%0d required idle", nm, busy, exp_a.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic new_test();
        done_cnt = 0;
        obs_a.delete();
        obs_d.delete();
    endtask

    // SDRAM ack responder
    initial begin : responder
        int age = 0;
        forever begin
            @(posedge clk); #1;
            if (ack_auto) begin
                ack_auto = 1'b0;
            end else if (ack_en && sdram_req) begin
                if (age >= ack_dly) begin
                    ack_auto = 1'b1;
                    age = 0;
                    outstanding--;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    // compare process
    logic          req_prev = 1'b0;
    logic [AW-1:0] hold_a = '0;
    logic [31:0]   hold_d = '0;
    always @(negedge clk) begin
        chk("we_eq_req", sdram_we, sdram_req);
        if (done) done_cnt++;
        if (sdram_req && !req_prev) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_req actual addr=%0h data=%0h required no request", sdram_addr, sdram_data);
            end else begin
                chk("wr_addr", sdram_addr, exp_a.pop_front());
                chk("wr_data", sdram_data, exp_d.pop_front());
            end
            obs_a.push_back(sdram_addr);
            obs_d.push_back(sdram_data);
            hold_a = sdram_addr;
            hold_d = sdram_data;
        end else if (sdram_req) begin
            chk("req_stable_addr", sdram_addr, hold_a);
            chk("req_stable_data", sdram_data, hold_d);
        end
        req_prev = sdram_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear_word();
        ack_en = 1'b1;
        #3;
        chk("rst_req", sdram_req, 0);
        chk("rst_we", sdram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_data", sdram_data, 0);
        @(posedge clk); #1;

        // full word, accepted on the first clock after reset release
        reset_n = 1'b1;
        new_test();
        dl_up();
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        send_byte(25'd2, 8'h33);
        send_byte(25'd3, 8'h44);
        chk("lat_n1_req", sdram_req, 0);
        dl_down();
        chk("lat_n2_req", sdram_req, 1);
        wait_drain("t1");
        chk("t1_nwr", obs_a.size(), 1);
        chk("t1_addr_lit", obs_a[0], 0);
        chk("t1_data_lit", obs_d[0], 32'h44332211);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy", busy, 0);

        // partial word flushed at download end
        new_test();
        dl_up();
        send_byte(25'd8, 8'hAA);
        send_byte(25'd9, 8'hBB);
        dl_down();
        wait_drain("t2");
        chk("t2_nwr", obs_a.size(), 1);
        chk("t2_addr_lit", obs_a[0], 2);
        chk("t2_data_lit", obs_d[0], 32'h0000BBAA);
        chk("t2_done_cnt", done_cnt, 1);

        // address change evicts the partial word
        new_test();
        dl_up();
        send_byte(25'd4, 8'h55);
        send_byte(25'd12, 8'h66);
        repeat (8) @(posedge clk);
        #1;
        chk("t3_early_nwr", obs_a.size(), 1);
        dl_down();
        wait_drain("t3");
        chk("t3_nwr", obs_a.size(), 2);
        chk("t3_addr0_lit", obs_a[0], 1);
        chk("t3_data0_lit", obs_d[0], 32'h00000055);
        chk("t3_addr1_lit", obs_a[1], 3);
        chk("t3_data1_lit", obs_d[1], 32'h00000066);

        // lane-3 byte at a new address while a partial word is pending, back to back
        new_test();
        dl_up();
        send_byte(25'd16, 8'hAB);
        send_byte(25'd23, 8'hCD);
        send_byte(25'd24, 8'hEF);
        dl_down();
        wait_drain("t4");
        chk("t4_nwr", obs_a.size(), 3);
        chk("t4_addr0_lit", obs_a[0], 4);
        chk("t4_data0_lit", obs_d[0], 32'h000000AB);
        chk("t4_addr1_lit", obs_a[1], 5);
        chk("t4_data1_lit", obs_d[1], 32'hCD000000);
        chk("t4_addr2_lit", obs_a[2], 6);
        chk("t4_data2_lit", obs_d[2], 32'h000000EF);

        // overflow: ack held off while 6 words arrive
        new_test();
        ack_en = 1'b0;
        dl_up();
        for (int i = 0; i < 24; i++) send_byte(25'(64 + i), 8'(i));
        dl_down();
        repeat (3) @(posedge clk);
        #1;
        chk("t5_ovf", overflow, exp_ovf);
        chk("t5_ovf_lit", overflow, 1);
        chk("t5_req_held", sdram_req, 1);
        ack_en = 1'b1;
        wait_drain("t5");
        chk("t5_nwr", obs_a.size(), 4);
        for (int i = 0; i < 4; i++) chk("t5_addr_lit", obs_a[i], 64'(16 + i));
        chk("t5_data0_lit", obs_d[0], 32'h03020100);
        chk("t5_ovf_sticky", overflow, 1);
        dl_up();
        @(posedge clk); #1;
        chk("t5_ovf_clear", overflow, 0);
        dl_down();
        wait_drain("t5b");

        // reset in the middle of a request
        new_test();
        ack_en = 1'b0;
        dl_up();
        send_byte(25'd3, 8'h77);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_req_before", sdram_req, 1);
        #2;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        chk("t6_rst_req", sdram_req, 0);
        chk("t6_rst_we", sdram_we, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_addr", sdram_addr, 0);
        exp_a.delete();
        exp_d.delete();
        outstanding = 0;
        model_clear_word();
        @(posedge clk); #1;
        reset_n = 1'b1;
        done_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt, 0);
        chk("t6_busy_after", busy, 0);
        new_test();
        ack_en = 1'b1;
        dl_up();
        for (int i = 0; i < 4; i++) send_byte(25'(32 + i), 8'(i + 1));
        dl_down();
        wait_drain("t6");
        chk("t6_nwr", obs_a.size(), 1);
        chk("t6_addr_lit", obs_a[0], 8);
        chk("t6_data_lit", obs_d[0], 32'h04030201);

        // strobes outside a download and a stray ack
        new_test();
        send_byte(25'd3, 8'h99);
        send_byte(25'd7, 8'h98);
        ack_stray = 1'b1;
        @(posedge clk); #1;
        ack_stray = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t7_req", sdram_req, 0);
        chk("t7_busy", busy, 0);
        chk("t7_nwr", obs_a.size(), 0);
        chk("t7_done_cnt", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
